// File: rtl/array_18_ctrl.sv
// Sequencer/arbiter in front of a single-port masked SRAM macro: zero-fills the
// array after reset, then round-robins the RW port between one writer and one reader.
module array_18_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 160,
    parameter int LANES   = 10,
    parameter int INIT_EN = 1
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_done,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LANES-1:0]  wr_mask,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LANES-1:0]  mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    localparam state_t RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic              rd_vld_p1;
    logic              rd_pri;

    logic              hold_wmode;
    logic [ADDR_W-1:0] hold_addr;
    logic [LANES-1:0]  hold_mask;
    logic [DATA_W-1:0] hold_data;

    logic run;
    logic rd_elig;
    logic wr_elig;
    logic rd_grant;
    logic wr_grant;

    // A read may issue only when nothing is inflight and the response slot frees this cycle.
    assign run      = (state == ST_RUN);
    assign rd_elig  = run && rd_valid && !rd_vld_p1 && (!resp_valid || resp_ready);
    assign wr_elig  = run && wr_valid;
    assign rd_grant = rd_elig && (rd_pri || !wr_elig);
    assign wr_grant = wr_elig && !rd_grant;
    assign rd_ready = rd_grant;
    assign wr_ready = wr_grant;

    always_comb begin
        mem_en    = 1'b0;
        mem_wmode = hold_wmode;
        mem_addr  = hold_addr;
        mem_wmask = hold_mask;
        mem_wdata = hold_data;
        if (!reset) begin
            mem_en = 1'b0;
        end else if (state == ST_INIT) begin
            mem_en    = 1'b1;
            mem_wmode = 1'b1;
            mem_addr  = init_cnt;
            mem_wmask = '1;
            mem_wdata = '0;
        end else if (wr_grant) begin
            mem_en    = 1'b1;
            mem_wmode = 1'b1;
            mem_addr  = wr_addr;
            mem_wmask = wr_mask;
            mem_wdata = wr_data;
        end else if (rd_grant) begin
            mem_en    = 1'b1;
            mem_wmode = 1'b0;
            mem_addr  = rd_addr;
        end
    end

    // Idle cycles replay the last issued command fields to keep macro pins quiet.
    always_ff @(posedge clock) begin
        if (mem_en) begin
            hold_wmode <= mem_wmode;
            hold_addr  <= mem_addr;
            hold_mask  <= mem_wmask;
            hold_data  <= mem_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= RST_STATE;
            init_done  <= (INIT_EN == 0);
            init_cnt   <= '0;
            rd_vld_p1  <= 1'b0;
            rd_pri     <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (&init_cnt) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (rd_grant) begin
                        rd_pri <= 1'b0;
                    end else if (wr_grant) begin
                        rd_pri <= 1'b1;
                    end
                end
                default: state <= RST_STATE;
            endcase

            // p1: macro data arrives; a capture takes priority over a handshake clear.
            rd_vld_p1 <= rd_grant;
            if (rd_vld_p1) begin
                resp_valid <= 1'b1;
                resp_data  <= mem_rdata;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_array_18_ctrl.sv
// Scoreboard bench for array_18_ctrl with a behavioural masked SRAM behind the macro port.
module tb_array_18_ctrl;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 160;
    localparam int LANES  = 10;
    localparam int LW     = 16;

    localparam logic [DATA_W-1:0] D1 = 160'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_DEAD_BEEF;
    localparam logic [DATA_W-1:0] D2 = 160'hA5A5_0001_0002_0003_0004_0005_0006_0007_0008_5A5A;
    localparam logic [DATA_W-1:0] D3 = 160'hC0DE_C0DE_1111_2222_3333_4444_5555_6666_7777_8888;

    logic              clock = 1'b0;
    logic              reset;
    logic              init_done;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [LANES-1:0]  wr_mask;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              mem_en;
    logic              mem_wmode;
    logic [ADDR_W-1:0] mem_addr;
    logic [LANES-1:0]  mem_wmask;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    array_18_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES), .INIT_EN(1)) dut (
        .clock(clock), .reset(reset), .init_done(init_done),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_mask(wr_mask), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_addr(mem_addr),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Behavioural macro, preloaded with non-zero junk so the zero-fill is observable.
    logic [DATA_W-1:0] mem_arr [0:(1<<ADDR_W)-1];
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem_arr[i] = {10{16'hDEAD}};
    end
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_wmode) begin
                for (int l = 0; l < LANES; l++)
                    if (mem_wmask[l]) mem_arr[mem_addr][l*LW +: LW] <= mem_wdata[l*LW +: LW];
            end else begin
                mem_rdata <= mem_arr[mem_addr];
            end
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [DATA_W-1:0] exp_q[$];
    int                grant_q[$];
    logic              prev_valid = 1'b0;
    int                mon_g;

    // Monitor: latency on each new response, data on each handshake.
    always @(negedge clock) begin
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            if (resp_valid && !prev_valid) begin
                if (grant_q.size() == 0) begin
                    check("resp_unexpected_valid", DATA_W'(1), DATA_W'(0));
                end else begin
                    mon_g = grant_q.pop_front();
                    check("resp_latency", DATA_W'(cyc - mon_g), DATA_W'(2));
                end
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) check("resp_unexpected_data", DATA_W'(1), DATA_W'(0));
                else check("resp_data", resp_data, exp_q.pop_front());
            end
            prev_valid = resp_valid;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic init_scan();
        int bad = 0;
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            if (i > 0) @(negedge clock);
            if (!(mem_en === 1'b1 && mem_wmode === 1'b1 && mem_addr === ADDR_W'(i) &&
                  mem_wmask === 10'h3FF && mem_wdata === '0 && wr_ready === 1'b0 &&
                  rd_ready === 1'b0 && init_done === 1'b0)) bad++;
            if (i == (1 << ADDR_W) - 1) begin
                wr_valid = 1'b0;
                rd_valid = 1'b0;
            end
        end
        check("init_seq_bad_cycles", DATA_W'(bad), DATA_W'(0));
        @(negedge clock);
        check("init_done_rise", DATA_W'(init_done), DATA_W'(1));
        check("post_init_mem_idle", DATA_W'(mem_en), DATA_W'(0));
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [LANES-1:0] m, input logic [DATA_W-1:0] d);
        int n = 0;
        @(posedge clock); #1;
        wr_valid = 1'b1; wr_addr = a; wr_mask = m; wr_data = d;
        @(negedge clock);
        while (!wr_ready && n < 20) begin @(negedge clock); n++; end
        if (!wr_ready) begin
            check("wr_grant_timeout", DATA_W'(0), DATA_W'(1));
        end else begin
            check("wr_issue_ctrl", DATA_W'({mem_en, mem_wmode, mem_addr, mem_wmask}), DATA_W'({2'b11, a, m}));
            check("wr_issue_data", mem_wdata, d);
        end
        @(posedge clock); #1;
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] expd);
        int n = 0;
        @(posedge clock); #1;
        rd_valid = 1'b1; rd_addr = a;
        @(negedge clock);
        while (!rd_ready && n < 20) begin @(negedge clock); n++; end
        if (!rd_ready) begin
            check("rd_grant_timeout", DATA_W'(0), DATA_W'(1));
        end else begin
            check("rd_issue_ctrl", DATA_W'({mem_en, mem_wmode, mem_addr}), DATA_W'({2'b10, a}));
            exp_q.push_back(expd);
            grant_q.push_back(cyc);
        end
        @(posedge clock); #1;
        rd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1; resp_ready = 1'b1;
        wr_addr = '0; wr_mask = '0; wr_data = '0; rd_addr = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_init_done", DATA_W'(init_done), DATA_W'(0));
        check("rst_resp", DATA_W'({resp_valid, resp_data}), DATA_W'(0));
        check("rst_mem_en", DATA_W'(mem_en), DATA_W'(0));
        check("rst_readies", DATA_W'({wr_ready, rd_ready}), DATA_W'(0));

        reset = 1'b1; #1;
        init_scan();

        // Both requesters saturated: R,W,R,W,... starting with read.
        @(posedge clock); #1;
        wr_valid = 1'b1; wr_addr = 12'h040; wr_mask = 10'h3FF; wr_data = D2;
        rd_valid = 1'b1; rd_addr = 12'h040;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("arb_rd_ready", DATA_W'(rd_ready), DATA_W'(i % 2 == 0));
            check("arb_wr_ready", DATA_W'(wr_ready), DATA_W'(i % 2 == 1));
            if (rd_ready) begin
                exp_q.push_back(i == 0 ? '0 : D2);
                grant_q.push_back(cyc);
            end
        end
        @(posedge clock); #1;
        wr_valid = 1'b0; rd_valid = 1'b0;
        idle(4);

        do_write(12'h123, 10'h3FF, D1);
        do_read(12'h123, D1);
        idle(4);
        do_write(12'h005, 10'h001, {{9{16'hAAAA}}, 16'hBEEF});
        do_read(12'h005, {144'h0, 16'hBEEF});
        idle(4);
        do_write(12'h005, 10'h200, {16'h7777, {9{16'h1111}}});
        do_read(12'h005, {16'h7777, 128'h0, 16'hBEEF});
        idle(4);
        do_write(12'h123, 10'h000, {10{16'h5555}});
        do_read(12'h123, D1);
        idle(4);

        // Backpressure: held response blocks reads but not writes.
        @(posedge clock); #1;
        resp_ready = 1'b0;
        do_read(12'h040, D2);
        n = 0;
        @(negedge clock);
        while (!resp_valid && n < 10) begin @(negedge clock); n++; end
        check("bp_resp_arrives", DATA_W'(resp_valid), DATA_W'(1));
        @(posedge clock); #1;
        rd_valid = 1'b1; rd_addr = 12'h005;
        wr_valid = 1'b1; wr_addr = 12'h300; wr_mask = 10'h3FF; wr_data = D3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp_rd_ready", DATA_W'(rd_ready), DATA_W'(0));
            check("bp_wr_ready", DATA_W'(wr_ready), DATA_W'(1));
            check("bp_resp_hold", DATA_W'({resp_valid, resp_data}), DATA_W'({1'b1, D2}));
        end
        @(posedge clock); #1;
        resp_ready = 1'b1; wr_valid = 1'b0;
        @(negedge clock);
        check("bp_release_rd_ready", DATA_W'(rd_ready), DATA_W'(1));
        if (rd_ready) begin
            exp_q.push_back({16'h7777, 128'h0, 16'hBEEF});
            grant_q.push_back(cyc);
        end
        @(posedge clock); #1;
        rd_valid = 1'b0;
        idle(4);
        do_read(12'h300, D3);
        idle(4);

        // Reset with a read inflight: response dropped, INIT restarts from 0.
        @(posedge clock); #1;
        rd_valid = 1'b1; rd_addr = 12'h123;
        @(negedge clock);
        check("mid_rd_grant", DATA_W'(rd_ready), DATA_W'(1));
        @(posedge clock); #1;
        rd_valid = 1'b0;
        reset = 1'b0; #1;
        check("mid_rst_resp_valid", DATA_W'(resp_valid), DATA_W'(0));
        check("mid_rst_init_done", DATA_W'(init_done), DATA_W'(0));
        check("mid_rst_mem_en", DATA_W'(mem_en), DATA_W'(0));
        @(negedge clock);
        reset = 1'b1; #1;
        init_scan();

        // Pointer must be back to read priority; array is zero again.
        @(posedge clock); #1;
        wr_valid = 1'b1; wr_addr = 12'h123; wr_mask = 10'h3FF; wr_data = D3;
        rd_valid = 1'b1; rd_addr = 12'h123;
        @(negedge clock);
        check("rerun_rd_first", DATA_W'({rd_ready, wr_ready}), DATA_W'(2'b10));
        if (rd_ready) begin
            exp_q.push_back('0);
            grant_q.push_back(cyc);
        end
        @(posedge clock); #1;
        wr_valid = 1'b0; rd_valid = 1'b0;
        idle(6);

        check("end_exp_q_empty", DATA_W'(exp_q.size()), DATA_W'(0));
        check("end_grant_q_empty", DATA_W'(grant_q.size()), DATA_W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/array_18_ctrl.md
Name: array_18_ctrl

Overview:
- Sequencer/arbiter for one 4096x160 single-port masked SRAM macro: 10 lanes of 16 bits, 1-cycle registered-address read.
- After reset, zero-fills the whole array, then shares the single RW port between one write requester and one read requester.
- Round-robin arbitration; read data returned through a one-entry response register with backpressure.
- Sits between the owning pipeline stage and the macro instance.

Parameters:
ADDR_W, 12, macro address width (depth 2^ADDR_W)
DATA_W, 160, macro data width
LANES, 10, write-mask lanes (DATA_W/LANES bits each)
INIT_EN, 1, 1 = zero-fill array after reset; 0 = ready immediately

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
init_done  out  1  high once zero-fill is complete
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_addr  in  ADDR_W  write address
wr_mask  in  LANES  per-lane write enable
wr_data  in  DATA_W  write data
rd_valid  in  1  read request
rd_ready  out  1  read accepted when rd_valid && rd_ready
rd_addr  in  ADDR_W  read address
resp_valid  out  1  read data available
resp_ready  in  1  read data consumed when resp_valid && resp_ready
resp_data  out  DATA_W  read data
mem_en  out  1  macro enable
mem_wmode  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  macro address
mem_wmask  out  LANES  macro lane mask
mem_wdata  out  DATA_W  macro write data
mem_rdata  in  DATA_W  macro read data, valid the cycle after a read enable

Behaviour:
- Reset (async, reset=0) clears all state at once:
  - init_done=0 (1 if INIT_EN=0); resp_valid=0; resp_data=0.
  - Inflight flag=0; round-robin pointer=read-priority; init counter=0.
  - mem_en=0, so no macro access while reset is asserted.
- State machine: INIT -> RUN. RUN is never left except by reset.
- INIT (only if INIT_EN=1), one write per cycle:
  - Drives mem_en=1, mem_wmode=1, mem_addr=counter, mem_wmask=all ones, mem_wdata=0.
  - Counter increments 0..4095; takes exactly 4096 cycles after reset release.
  - After the cycle writing 4095, init_done=1 and state=RUN. init_done is sticky until reset.
  - wr_ready=rd_ready=0 throughout INIT.
- RUN eligibility:
  - Write eligible when wr_valid.
  - Read eligible when rd_valid && !inflight && (!resp_valid || resp_ready).
  - At most one read outstanding (inflight or held).
- Arbitration:
  - Only one request is eligible: it is granted.
  - Both are eligible: the pointer selects the winner.
  - After any grant, the pointer points to the other requester.
  - The pointer changes only on an actual grant.
- Ready outputs:
  - wr_ready = RUN && write granted. rd_ready = RUN && read granted.
  - Both are combinational from the valids and state. Never both high in one cycle.
- Write grant, cycle T: mem_en=1, mem_wmode=1, addr/mask/data passed through unchanged.
  - A mask of 0 is still accepted and issued; the array is unchanged.
- Read grant, cycle T:
  - mem_en=1, mem_wmode=0, mem_addr=rd_addr; inflight set.
  - T+1: resp_data <= mem_rdata, resp_valid <= 1, inflight cleared. resp_valid is visible from T+2.
  - Request-to-response latency is 2 cycles.
- No grant in a cycle: mem_en=0; other mem_* outputs are don't-care, held at their last value.
- Response register:
  - resp_valid and resp_data hold steady while resp_valid && !resp_ready.
  - The register clears on handshake unless a new capture occurs in the same cycle; capture wins.
- Ordering: a write granted before a read to the same address is visible to that read, since the accesses are sequential.
  - A read granted before a write returns the old data.
- Reset mid-operation: an inflight read is dropped, resp_valid goes to 0, and INIT restarts from address 0.

Test Plan:
- Reset, then idle with INIT_EN=1 -> mem_en=1/wmode=1 for exactly 4096 cycles at addresses 0..4095 with mask 0x3FF and data 0. init_done rises after the 4096th. rd_ready/wr_ready=0 throughout.
- After init: write addr 0x123, mask 0x3FF, data D; then read 0x123 -> resp_valid 2 cycles after the read grant with resp_data=D.
- Write addr 5 mask 0x001 data 0xBEEF in lane 0 (pattern elsewhere); read 5 -> resp_data = 0x...0000BEEF, upper lanes 0 from init.
- wr_valid and rd_valid held high continuously with resp_ready=1 -> grants alternate, starting with read after reset. Never both ready. Read accepted at most every 2 cycles, write fills the gaps.
- resp_ready=0 with a response held -> rd_ready=0 and resp_data stable for 10 cycles. Writes are still granted. Raising resp_ready re-enables reads in the same cycle.
- Assert reset with a read inflight during RUN -> resp_valid=0 immediately, init_done=0, and INIT rescans from 0 after release.
